// File: rtl/afbc_decompressor_if.sv
// Handshake bundle between the AFBC decompressor and its neighbours:
// compressed-block input stream and pixel output stream.
interface afbc_decompressor_if #(
    parameter int PIX_W = 32,
    parameter int CMP_W = 1024
);
    logic             cmp_valid;
    logic             cmp_ready;
    logic [CMP_W-1:0] cmp_data;
    logic             px_valid;
    logic             px_ready;
    logic [PIX_W-1:0] px_data;
    logic             px_last;
    logic             px_err;

    modport master (
        output cmp_valid, cmp_data, px_ready,
        input  cmp_ready, px_valid, px_data, px_last, px_err
    );

    modport slave (
        input  cmp_valid, cmp_data, px_ready,
        output cmp_ready, px_valid, px_data, px_last, px_err
    );
endinterface

// File: rtl/afbc_decompressor.sv
// Expands one compressed 1024-bit AFBC block word into a 32-beat RGBA pixel
// stream; malformed headers still emit a full block of flagged zero pixels.
module afbc_decompressor #(
    parameter int NPIX  = 32,
    parameter int PIX_W = 32,
    parameter int CMP_W = 1024
) (
    input  logic               clk,
    input  logic               rst,
    afbc_decompressor_if.slave bus,
    output logic [31:0]        perf_blocks_out,
    output logic [31:0]        perf_bad_hdr
);
    localparam int         PAY_W    = CMP_W - 32;
    localparam logic [4:0] LAST_IDX = 5'(NPIX - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t             state_r;
    logic [7:0]         mode_r;
    logic [23:0]        size_r;
    logic [PAY_W-1:0]   payload_r;
    logic [4:0]         idx_r;
    logic               err_r;
    logic               cmp_ready_r;
    logic               px_valid_r;
    logic               px_last_r;
    logic               px_err_r;
    logic [PIX_W-1:0]   px_data_r;
    logic [31:0]        blocks_r;
    logic [31:0]        bad_r;

    logic [4:0]         next_idx_s;
    logic [4:0]         raw_idx_s;
    logic [PIX_W-1:0]   pix_s;
    logic               bad_s;

    // Per-channel interpolation; the arithmetic shift floors negative steps.
    function automatic logic [31:0] lerp_pixel(input logic [31:0] first,
                                               input logic [31:0] last,
                                               input logic [4:0]  i);
        logic [31:0]        res;
        logic signed [8:0]  d;
        logic signed [14:0] prod;
        logic signed [14:0] sh;
        res = 32'd0;
        for (int c = 0; c < 4; c++) begin
            d    = $signed({1'b0, last[c*8 +: 8]}) - $signed({1'b0, first[c*8 +: 8]});
            prod = 15'(d) * 15'($signed({1'b0, i}));
            sh   = prod >>> 5;
            res[c*8 +: 8] = first[c*8 +: 8] + sh[7:0];
        end
        return res;
    endfunction

    // Header validation and the value of the pixel loaded at the next beat.
    always_comb begin
        next_idx_s = 5'd0;
        raw_idx_s  = 5'd0;
        pix_s      = '0;
        bad_s      = 1'b1;
        if (state_r == DECODE) begin
            next_idx_s = 5'd0;
        end else begin
            next_idx_s = idx_r + 5'd1;
        end
        // Raw payload holds only 31 words; the final pixel repeats the top one.
        if (next_idx_s == 5'd31) begin
            raw_idx_s = 5'd30;
        end else begin
            raw_idx_s = next_idx_s;
        end
        case (mode_r)
            8'd0: begin
                bad_s = (size_r != 24'd4);
                pix_s = payload_r[31:0];
            end
            8'd1: begin
                bad_s = (size_r != 24'd124);
                pix_s = payload_r[{raw_idx_s, 5'd0} +: 32];
            end
            8'd2: begin
                bad_s = (size_r != 24'd8);
                pix_s = lerp_pixel(payload_r[63:32], payload_r[31:0], next_idx_s);
            end
            8'd3: begin
                bad_s = (size_r != 24'd16);
                pix_s = payload_r[{next_idx_s[4:3], 5'd0} +: 32];
            end
            default: begin
                bad_s = 1'b1;
                pix_s = '0;
            end
        endcase
    end

    // Block FSM with registered handshake, pixel and counter outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            mode_r      <= 8'd0;
            size_r      <= 24'd0;
            payload_r   <= '0;
            idx_r       <= 5'd0;
            err_r       <= 1'b0;
            cmp_ready_r <= 1'b1;
            px_valid_r  <= 1'b0;
            px_last_r   <= 1'b0;
            px_err_r    <= 1'b0;
            px_data_r   <= '0;
            blocks_r    <= 32'd0;
            bad_r       <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.cmp_valid && cmp_ready_r) begin
                        mode_r      <= bus.cmp_data[CMP_W-1 -: 8];
                        size_r      <= bus.cmp_data[CMP_W-9 -: 24];
                        payload_r   <= bus.cmp_data[PAY_W-1:0];
                        cmp_ready_r <= 1'b0;
                        state_r     <= DECODE;
                    end else begin
                        cmp_ready_r <= 1'b1;
                    end
                end
                DECODE: begin
                    err_r      <= bad_s;
                    px_data_r  <= bad_s ? '0 : pix_s;
                    px_valid_r <= 1'b1;
                    px_last_r  <= (LAST_IDX == 5'd0);
                    px_err_r   <= bad_s;
                    idx_r      <= 5'd0;
                    if (bad_s) begin
                        bad_r <= bad_r + 32'd1;
                    end
                    state_r    <= STREAM;
                end
                STREAM: begin
                    if (px_valid_r && bus.px_ready) begin
                        if (idx_r == LAST_IDX) begin
                            px_valid_r  <= 1'b0;
                            px_last_r   <= 1'b0;
                            px_err_r    <= 1'b0;
                            blocks_r    <= blocks_r + 32'd1;
                            cmp_ready_r <= 1'b1;
                            state_r     <= IDLE;
                        end else begin
                            idx_r     <= next_idx_s;
                            px_data_r <= err_r ? '0 : pix_s;
                            px_last_r <= (next_idx_s == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cmp_ready_r <= 1'b1;
                    px_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmp_ready   = cmp_ready_r;
    assign bus.px_valid    = px_valid_r;
    assign bus.px_data     = px_data_r;
    assign bus.px_last     = px_last_r;
    assign bus.px_err      = px_err_r;
    assign perf_blocks_out = blocks_r;
    assign perf_bad_hdr    = bad_r;
endmodule
